// File: rtl/pulse_gen_pkg.sv
// Shared types for the trapezoidal pulse generator: FSM states, default widths
// and the configuration record.
package pulse_gen_pkg;

    localparam int DEF_W  = 16;
    localparam int DEF_CW = 24;

    typedef enum logic [2:0] {
        IDLE,
        CALC,
        DELAY,
        RISE,
        HIGH,
        FALL,
        LOW,
        DONE
    } pg_state_t;

    typedef struct packed {
        logic [DEF_W-1:0]  iv;
        logic [DEF_W-1:0]  pv;
        logic [DEF_CW-1:0] td;
        logic [DEF_CW-1:0] tr;
        logic [DEF_CW-1:0] th;
        logic [DEF_CW-1:0] tf;
        logic [DEF_CW-1:0] tl;
        logic              oneshot;
    } pg_cfg_t;

endpackage

// File: rtl/serial_div.sv
// Restoring unsigned divider, one quotient bit per cycle. The first bit is
// resolved on the start edge, so results are ready W cycles after start.
module serial_div
    import pulse_gen_pkg::*;
#(
    parameter int W  = DEF_W,
    parameter int CW = DEF_CW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [W-1:0]  dividend,
    input  logic [CW-1:0] divisor,
    output logic          busy,
    output logic          done,
    output logic [W-1:0]  quotient,
    output logic [CW-1:0] remainder
);

    localparam int SW = $clog2(W + 1);

    logic [CW-1:0] dvs;
    logic [SW-1:0] steps;

    logic [CW-1:0] step_rem_in;
    logic [W-1:0]  step_quo_in;
    logic [CW-1:0] step_dvs;
    logic [CW:0]   shifted;
    logic          fits;
    logic [CW-1:0] step_rem;
    logic [W-1:0]  step_quo;

    // A start restarts the divider even if a previous division is in flight.
    always_comb begin
        step_rem_in = start ? '0 : remainder;
        step_quo_in = start ? dividend : quotient;
        step_dvs    = start ? divisor : dvs;
        shifted     = {step_rem_in, step_quo_in[W-1]};
        fits        = (shifted >= {1'b0, step_dvs});
        step_rem    = fits ? (shifted[CW-1:0] - step_dvs) : shifted[CW-1:0];
        step_quo    = {step_quo_in[W-2:0], fits};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dvs       <= '0;
            steps     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
        end else begin
            done <= 1'b0;
            if (start) begin
                dvs       <= divisor;
                quotient  <= step_quo;
                remainder <= step_rem;
                steps     <= SW'(W - 1);
                busy      <= 1'b1;
            end else if (busy) begin
                quotient  <= step_quo;
                remainder <= step_rem;
                steps     <= steps - SW'(1);
                if (steps == SW'(1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/pulse_wave_gen.sv
// Trapezoidal pulse waveform generator: delay, linear rise, high, linear fall,
// low, repeated or one-shot, with exact integer ramps from a DDA accumulator.
module pulse_wave_gen
    import pulse_gen_pkg::*;
#(
    parameter int W  = DEF_W,
    parameter int CW = DEF_CW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cfg_valid,
    output logic          cfg_ready,
    input  logic [W-1:0]  cfg_iv,
    input  logic [W-1:0]  cfg_pv,
    input  logic [CW-1:0] cfg_td,
    input  logic [CW-1:0] cfg_tr,
    input  logic [CW-1:0] cfg_th,
    input  logic [CW-1:0] cfg_tf,
    input  logic [CW-1:0] cfg_tl,
    input  logic          cfg_oneshot,
    input  logic          abort,
    output logic          out_valid,
    output logic [W-1:0]  out_sample,
    output logic          period_done,
    output logic          done
);

    // Handshake: a config transfers on a clock edge where cfg_valid and
    // cfg_ready are both high; cfg_ready depends only on state and abort.

    localparam int NW = $clog2(2 * W + 2);
    localparam logic [NW-1:0] DIV1_END = NW'(W);
    localparam logic [NW-1:0] DIV2_END = NW'(2 * W);
    localparam logic [NW-1:0] CALC_END = NW'(2 * W + 1);

    pg_state_t state, state_nxt;

    logic [W-1:0]  iv, pv;
    logic [CW-1:0] td, tr, th, tf, tl;
    logic          oneshot;

    logic          dir;
    logic [W-1:0]  delta;
    logic [NW-1:0] calc_cnt;
    logic [W-1:0]  q_rise, q_fall;
    logic [CW-1:0] r_rise, r_fall;

    logic [CW-1:0] dur, dur_nxt;
    logic [CW-1:0] th_m1, tl_m1;
    logic          entry;
    pg_state_t     rise_or_high, fall_or_end, low_or_done;

    logic          ramp_rise, ramp_now, ramp_up, carry;
    logic [CW-1:0] ramp_t, ramp_r;
    logic [W-1:0]  ramp_q, ramp_from, ramp_level;
    logic [W:0]    acc_off, off_base, off_nxt;
    logic [CW:0]   acc_err, err_base, err_sum, err_nxt;

    logic          valid_nxt, pd_nxt, done_nxt;
    logic [W-1:0]  sample_nxt;

    logic          div_start, div_busy, div_done;
    logic [CW-1:0] div_divisor, div_rem;
    logic [W-1:0]  div_quo;

    assign cfg_ready = (state == IDLE) && !abort;

    assign dir   = (pv >= iv);
    assign delta = dir ? (pv - iv) : (iv - pv);
    assign th_m1 = (th == '0) ? '0 : th - CW'(1);
    assign tl_m1 = (tl == '0) ? '0 : tl - CW'(1);

    // Zero-length ramps are skipped so the following level applies at once.
    assign rise_or_high = (tr != '0) ? RISE : HIGH;
    assign low_or_done  = oneshot ? DONE : LOW;
    assign fall_or_end  = (tf != '0) ? FALL : low_or_done;

    assign div_divisor = (calc_cnt == DIV1_END) ? tf : tr;
    assign div_start   = (state == CALC) && !abort &&
                         (((calc_cnt == '0) && (tr != '0)) ||
                          ((calc_cnt == DIV1_END) && (tf != '0)));

    serial_div #(.W(W), .CW(CW)) u_div (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (div_start),
        .dividend  (delta),
        .divisor   (div_divisor),
        .busy      (div_busy),
        .done      (div_done),
        .quotient  (div_quo),
        .remainder (div_rem)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cfg_valid) state_nxt = CALC;
            CALC:    if (calc_cnt == CALC_END) state_nxt = (td != '0) ? DELAY : rise_or_high;
            DELAY:   if (dur == '0) state_nxt = rise_or_high;
            RISE:    if (dur == '0) state_nxt = HIGH;
            HIGH:    if (dur == '0) state_nxt = fall_or_end;
            FALL:    if (dur == '0) state_nxt = low_or_done;
            LOW:     if (dur == '0) state_nxt = rise_or_high;
            DONE:    state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
        if (abort) state_nxt = IDLE;
    end

    assign entry = (state_nxt != state);

    // dur holds the cycles remaining after the current one in this state.
    always_comb begin
        dur_nxt = dur;
        if (entry) begin
            case (state_nxt)
                DELAY:   dur_nxt = td - CW'(1);
                RISE:    dur_nxt = tr - CW'(1);
                HIGH:    dur_nxt = th_m1;
                FALL:    dur_nxt = tf - CW'(1);
                LOW:     dur_nxt = tl_m1;
                default: dur_nxt = '0;
            endcase
        end else if (dur != '0) begin
            dur_nxt = dur - CW'(1);
        end
    end

    // offset_k = floor(delta*k/t) tracked as q per step plus a carry from the
    // remainder accumulator, so the last ramp sample lands exactly on target.
    always_comb begin
        ramp_rise  = (state_nxt == RISE);
        ramp_now   = ramp_rise || (state_nxt == FALL);
        ramp_t     = ramp_rise ? tr : tf;
        ramp_q     = ramp_rise ? q_rise : q_fall;
        ramp_r     = ramp_rise ? r_rise : r_fall;
        ramp_from  = ramp_rise ? iv : pv;
        ramp_up    = ramp_rise ? dir : !dir;
        off_base   = entry ? '0 : acc_off;
        err_base   = entry ? '0 : acc_err;
        err_sum    = err_base + {1'b0, ramp_r};
        carry      = (err_sum >= {1'b0, ramp_t});
        err_nxt    = carry ? (err_sum - {1'b0, ramp_t}) : err_sum;
        off_nxt    = off_base + {1'b0, ramp_q} + {{W{1'b0}}, carry};
        ramp_level = ramp_up ? (ramp_from + off_nxt[W-1:0]) : (ramp_from - off_nxt[W-1:0]);
    end

    always_comb begin
        sample_nxt = out_sample;
        case (state_nxt)
            DELAY, LOW, DONE: sample_nxt = iv;
            HIGH:             sample_nxt = pv;
            RISE, FALL:       sample_nxt = ramp_level;
            default:          sample_nxt = out_sample;
        endcase
        valid_nxt = (state_nxt != IDLE) && (state_nxt != CALC);
        done_nxt  = (state_nxt == DONE);
        pd_nxt    = (dur_nxt == '0) &&
                    ((state_nxt == LOW) ||
                     (oneshot && ((state_nxt == FALL) || ((state_nxt == HIGH) && (tf == '0)))));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            dur         <= '0;
            calc_cnt    <= '0;
            iv          <= '0;
            pv          <= '0;
            td          <= '0;
            tr          <= '0;
            th          <= '0;
            tf          <= '0;
            tl          <= '0;
            oneshot     <= 1'b0;
            q_rise      <= '0;
            r_rise      <= '0;
            q_fall      <= '0;
            r_fall      <= '0;
            acc_off     <= '0;
            acc_err     <= '0;
            out_valid   <= 1'b0;
            out_sample  <= '0;
            period_done <= 1'b0;
            done        <= 1'b0;
        end else begin
            state    <= state_nxt;
            dur      <= dur_nxt;
            calc_cnt <= ((state == CALC) && (state_nxt == CALC)) ? calc_cnt + NW'(1) : '0;

            if (cfg_valid && cfg_ready) begin
                iv      <= cfg_iv;
                pv      <= cfg_pv;
                td      <= cfg_td;
                tr      <= cfg_tr;
                th      <= cfg_th;
                tf      <= cfg_tf;
                tl      <= cfg_tl;
                oneshot <= cfg_oneshot;
                q_rise  <= '0;
                r_rise  <= '0;
                q_fall  <= '0;
                r_fall  <= '0;
            end

            // A skipped division leaves its quotient/remainder at zero.
            if ((state == CALC) && div_done && !div_busy) begin
                if (calc_cnt == DIV1_END) begin
                    q_rise <= div_quo;
                    r_rise <= div_rem;
                end else if (calc_cnt == DIV2_END) begin
                    q_fall <= div_quo;
                    r_fall <= div_rem;
                end
            end

            acc_off     <= ramp_now ? off_nxt : '0;
            acc_err     <= ramp_now ? err_nxt : '0;
            out_valid   <= valid_nxt;
            out_sample  <= sample_nxt;
            period_done <= pd_nxt;
            done        <= done_nxt;
        end
    end

endmodule

// File: tb/tb_pulse_wave_gen.sv
// Directed bench for pulse_wave_gen: periodic, inverted, one-shot steps,
// abort, mid-run reset and full-scale ramp exactness.
module tb_pulse_wave_gen;
    import pulse_gen_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [15:0] cfg_iv, cfg_pv;
    logic [23:0] cfg_td, cfg_tr, cfg_th, cfg_tf, cfg_tl;
    logic        cfg_oneshot;
    logic        abort;
    logic        out_valid;
    logic [15:0] out_sample;
    logic        period_done;
    logic        done;

    int checks   = 0;
    int failures = 0;

    int t1_samp [17] = '{0, 0, 2, 5, 7, 10, 10, 10, 10, 8, 5, 3, 0, 0, 0, 2, 5};
    int t2_samp [13] = '{80, 60, 40, 40, 40, 60, 80, 100, 100, 80, 60, 40, 40};
    int t4_samp [18] = '{0, 9362, 18724, 28086, 37448, 46810, 56172, 65535, 65535,
                         56173, 46811, 37449, 28087, 18725, 9363, 0, 0, 0};

    pulse_wave_gen dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_iv      (cfg_iv),
        .cfg_pv      (cfg_pv),
        .cfg_td      (cfg_td),
        .cfg_tr      (cfg_tr),
        .cfg_th      (cfg_th),
        .cfg_tf      (cfg_tf),
        .cfg_tl      (cfg_tl),
        .cfg_oneshot (cfg_oneshot),
        .abort       (abort),
        .out_valid   (out_valid),
        .out_sample  (out_sample),
        .period_done (period_done),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic set_cfg(input logic [15:0] iv, input logic [15:0] pv,
                           input logic [23:0] td, input logic [23:0] tr,
                           input logic [23:0] th, input logic [23:0] tf,
                           input logic [23:0] tl, input logic os);
        pg_cfg_t c;
        c = '{iv: iv, pv: pv, td: td, tr: tr, th: th, tf: tf, tl: tl, oneshot: os};
        cfg_iv      = c.iv;
        cfg_pv      = c.pv;
        cfg_td      = c.td;
        cfg_tr      = c.tr;
        cfg_th      = c.th;
        cfg_tf      = c.tf;
        cfg_tl      = c.tl;
        cfg_oneshot = c.oneshot;
    endtask

    // Offers the config at a falling edge; returns at the falling edge of the
    // first CALC cycle with cfg_valid dropped.
    task automatic handshake(input string tag);
        int waited;
        waited    = 0;
        cfg_valid = 1'b1;
        #1;
        while (!cfg_ready && waited < 20) begin
            @(negedge clk);
            #1;
            waited++;
        end
        checks++;
        assert (cfg_ready === 1'b1) else begin
            failures++;
            $error("FAIL %s_hs got cfg_ready=%0b exp=1", tag, cfg_ready);
        end
        @(negedge clk);
        cfg_valid = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        abort     = 1'b0;
        cfg_valid = 1'b0;
        set_cfg(16'd0, 16'd0, 24'd0, 24'd0, 24'd0, 24'd0, 24'd0, 1'b0);

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(cfg_ready), 32'd1);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_sample", 32'(out_sample), 32'd0);
        chk("rst_pd", 32'(period_done), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        rst_n = 1'b1;

        // Basic periodic waveform, then abort in the 2nd RISE cycle of period 2
        set_cfg(16'd0, 16'd10, 24'd2, 24'd4, 24'd3, 24'd4, 24'd2, 1'b0);
        handshake("t1");
        chk("t1_calc_valid", 32'(out_valid), 32'd0);
        chk("t1_calc_ready", 32'(cfg_ready), 32'd0);
        repeat (33) @(negedge clk);
        chk("t1_calc_last", 32'(out_valid), 32'd0);
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            chk($sformatf("t1_valid[%0d]", i), 32'(out_valid), 32'd1);
            chk($sformatf("t1_sample[%0d]", i), 32'(out_sample), t1_samp[i]);
            chk($sformatf("t1_pd[%0d]", i), 32'(period_done), (i == 14) ? 32'd1 : 32'd0);
        end

        set_cfg(16'd100, 16'd40, 24'd0, 24'd3, 24'd2, 24'd3, 24'd1, 1'b0);
        abort     = 1'b1;
        cfg_valid = 1'b1;
        @(negedge clk);
        chk("ab_valid", 32'(out_valid), 32'd0);
        chk("ab_hold", 32'(out_sample), 32'd5);
        chk("ab_done", 32'(done), 32'd0);
        chk("ab_pd", 32'(period_done), 32'd0);
        chk("ab_ready", 32'(cfg_ready), 32'd0);
        @(negedge clk);
        chk("ab_defer_valid", 32'(out_valid), 32'd0);
        abort = 1'b0;
        #1;
        chk("ab_ready_after", 32'(cfg_ready), 32'd1);
        @(negedge clk);
        cfg_valid = 1'b0;

        // Inverted levels; a premature acceptance would shift this latency
        repeat (33) @(negedge clk);
        chk("t2_calc_last", 32'(out_valid), 32'd0);
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            chk($sformatf("t2_sample[%0d]", i), 32'(out_sample), t2_samp[i]);
            chk($sformatf("t2_range[%0d]", i), 32'(out_sample >= 16'd40 && out_sample <= 16'd100), 32'd1);
            chk($sformatf("t2_pd[%0d]", i), 32'(period_done), (i == 8) ? 32'd1 : 32'd0);
        end

        // Reset for one cycle during HIGH
        rst_n = 1'b0;
        @(negedge clk);
        chk("mr_valid", 32'(out_valid), 32'd0);
        chk("mr_sample", 32'(out_sample), 32'd0);
        chk("mr_pd", 32'(period_done), 32'd0);
        chk("mr_done", 32'(done), 32'd0);
        chk("mr_ready", 32'(cfg_ready), 32'd1);
        rst_n = 1'b1;

        // One-shot with all-zero durations
        set_cfg(16'd7, 16'd300, 24'd0, 24'd0, 24'd0, 24'd0, 24'd0, 1'b1);
        handshake("t3");
        repeat (33) @(negedge clk);
        chk("t3_calc_last", 32'(out_valid), 32'd0);
        @(negedge clk);
        chk("t3_first_valid", 32'(out_valid), 32'd1);
        chk("t3_first_sample", 32'(out_sample), 32'd300);
        chk("t3_first_pd", 32'(period_done), 32'd1);
        chk("t3_first_done", 32'(done), 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("t3_hold_sample[%0d]", i), 32'(out_sample), 32'd7);
            chk($sformatf("t3_hold_done[%0d]", i), 32'(done), 32'd1);
            chk($sformatf("t3_hold_pd[%0d]", i), 32'(period_done), 32'd0);
            chk($sformatf("t3_hold_valid[%0d]", i), 32'(out_valid), 32'd1);
        end
        chk("t3_done_ready", 32'(cfg_ready), 32'd0);
        abort = 1'b1;
        @(negedge clk);
        chk("t3_ab_valid", 32'(out_valid), 32'd0);
        chk("t3_ab_done", 32'(done), 32'd0);
        chk("t3_ab_hold", 32'(out_sample), 32'd7);
        abort = 1'b0;

        // Full-scale ramp exactness, one-shot
        set_cfg(16'd0, 16'd65535, 24'd1, 24'd7, 24'd1, 24'd7, 24'd0, 1'b1);
        handshake("t4");
        repeat (34) @(negedge clk);
        for (int i = 0; i < 18; i++) begin
            chk($sformatf("t4_sample[%0d]", i), 32'(out_sample), t4_samp[i]);
            chk($sformatf("t4_pd[%0d]", i), 32'(period_done), (i == 15) ? 32'd1 : 32'd0);
            chk($sformatf("t4_done[%0d]", i), 32'(done), (i >= 16) ? 32'd1 : 32'd0);
            @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pulse_wave_gen.md
# pulse_wave_gen

Synthesizable digital trapezoidal-pulse waveform generator. It produces the sampled drive code that feeds the pulse/rect current and voltage sources through a DAC-facing output. It covers both the periodic rectangular form (delay, rise, high, fall, low, repeat) and the one-shot pulse form, with exact integer linear ramps. Timing parameters are given in clock cycles.

## Interface
Parameters:
- `W`, 16, sample/amplitude code width
- `CW`, 24, duration counter width

Ports:
- `clk`  in  1  sole clock
- `rst_n`  in  1  reset; **synchronous, active-low**
- `cfg_valid`  in  1  configuration offered
- `cfg_ready`  out  1  configuration accepted this cycle when both high
- `cfg_iv`, `cfg_pv`  in  W  initial/pulse level codes; `pv < iv` allowed
- `cfg_td`, `cfg_tr`, `cfg_th`, `cfg_tf`, `cfg_tl`  in  CW  delay/rise/high/fall/low durations
- `cfg_oneshot`  in  1  1 = single pulse, 0 = periodic
- `abort`  in  1  synchronous stop
- `out_valid`  out  1  `out_sample` is a live waveform sample
- `out_sample`  out  W  waveform code
- `period_done`  out  1  one-cycle pulse on the last LOW cycle of each period
- `done`  out  1  one-shot finished, level

## Operation
- **States:** IDLE → CALC → DELAY → RISE → HIGH → FALL → LOW → RISE… In one-shot mode, FALL goes to DONE.
- **cfg_ready:** `cfg_ready = (state==IDLE) && !abort`. An accepted config is latched, and the block enters CALC.
- **CALC:** computes `delta = |pv-iv|`, `dir = (pv>=iv)`, `qr, rr = delta / tr`, and `qf, rf = delta / tf` with one shared serial divider, W iterations per division. A zero divisor skips its division.
- **Ramps:** DDA accumulator. Each cycle: `val += q`, `err += r`; if `err >= t`, then `err -= t` and `val += 1`.
  - The k-th RISE sample (k=1..tr) is exactly `iv ± floor(delta*k/tr)`, so the last sample equals `pv`.
  - FALL is symmetric from `pv` toward `iv` with `tf`.
  - Arithmetic is (W+1)-bit internally; the output never leaves `[min(iv,pv), max(iv,pv)]`.
- **Output per state:** DELAY outputs `iv` for `td` cycles. HIGH outputs `pv` for `th` cycles. LOW outputs `iv` for `tl` cycles. DONE holds `iv`.
- **Zero durations:**
  - `td=0` skips DELAY.
  - `tr=0` or `tf=0` gives an instantaneous step: the state is skipped, and the next state's level applies immediately.
  - `th=0` and `tl=0` are treated as 1, so the period is never zero.
- **Repetition:** periodic mode restarts at RISE after LOW; DELAY occurs only once per config.
- **abort:** any state → IDLE next cycle. `out_valid` drops, `out_sample` holds its last value, and `done` clears. Abort has priority over everything except reset.
- **Reset:**
  - State IDLE, `cfg_ready` = 1 (given `abort`=0).
  - `out_valid` = 0, `out_sample` = 0, `period_done` = 0, `done` = 0.
  - Divider and accumulators cleared.
  - Reset asserted mid-operation behaves identically.
- **Reconfiguration:** only from IDLE. Reaching IDLE again requires abort or reset; DONE returns to IDLE only on abort.

## Timing
- The config handshake completes in cycle c.
- CALC occupies cycles c+1 … c+2W+2 (fixed length, independent of skipped divisions). `out_valid` is 0 during CALC.
- The first waveform sample is registered and valid in cycle c+2W+3. `out_valid` stays 1 through all waveform states and DONE.
- All outputs are registered; sample latency from state entry is zero cycles.
- Per-period length is `tr + th' + tf + tl'` cycles, where `th'` and `tl'` are the values clamped to at least 1.
- `period_done` is high on the last LOW cycle, coincident with that sample. In one-shot mode it pulses on the last FALL cycle, and `done` rises the following cycle.

## Structure
- `pulse_gen_pkg`: state enum (IDLE, CALC, DELAY, RISE, HIGH, FALL, LOW, DONE), default `W`/`CW`, and the config struct type.
- Sub-module `serial_div`: restoring unsigned divider. It is W-bit dividend, CW-bit divisor, start/busy/done handshake, one quotient bit per cycle, and it outputs quotient and remainder.
- The top module holds the FSM, duration counter, DDA accumulator and output registers.

## Test plan
- **Basic periodic:** `iv=0, pv=10, td=2, tr=4, th=3, tf=4, tl=2`, periodic. After CALC, the samples are `0,0, 2,5,7,10, 10,10,10, 8,5,3,0, 0,0`, then `2,5,7,10…`. `period_done` is high on the 2nd 0 of each LOW.
- **Inverted levels:** `iv=100, pv=40, tr=3`. RISE samples are `80,60,40`, and the output is never outside [40,100].
- **One-shot steps:** `tr=0, tf=0, th=0, tl=0`, one-shot. Samples are `pv` (1 cycle) then `iv` held. `done`=1 from the next cycle, and `period_done` pulses once.
- **Abort mid-ramp:** abort in the 2nd RISE cycle gives IDLE next cycle with `out_valid`=0. With `cfg_valid` held high during abort, acceptance is deferred until `abort`=0.
- **Reset mid-HIGH:** `rst_n`=0 for 1 cycle gives all outputs at reset values next cycle. A new config then yields its first sample exactly 2W+3 cycles after the handshake.
- **Ramp exactness:** `delta=65535, tr=7`. Every RISE sample equals `floor(65535*k/7)`, and the final sample equals `pv` with no overflow.
